apb3_requester: RTL and testbench

APB3 requester (bus master) that converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers and returns read data and status on a valid/ready response stream.
Drives the completer side of the APB3 memory models and other peripherals in the DPI sample designs.
Handles completer wait states, PSLVERR, and an optional transfer timeout.

---
 rtl/apb3_pkg.sv | 22 ++
 rtl/apb3_requester.sv | 128 ++++++++++++
 tb/tb_apb3_requester.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb3_pkg.sv
// Shared types for the APB3 requester.
//   req_state_e : requester FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   rsp_t       : registered response payload {rdata, error, timeout}
package apb3_pkg;

  // Response data width; the requester's DataWidth parameter is expected to match.
  localparam int unsigned RSP_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } req_state_e;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  error;
    logic                  timeout;
  } rsp_t;

endpackage

// File: rtl/apb3_requester.sv
// APB3 requester: turns a valid/ready command stream into APB3 SETUP/ACCESS
// transfers and returns read data and status on a valid/ready response stream.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             command handshake
//   req_addr/req_write/req_wdata    command payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata/rsp_error/rsp_timeout response payload
//   paddr/pwrite/psel/penable/pwdata APB request signals
//   prdata/pready/pslverr           APB completer signals
module apb3_requester
  import apb3_pkg::*;
#(
  parameter int unsigned AddressWidth  = 8,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [AddressWidth-1:0] req_addr,
  input  logic                    req_write,
  input  logic [DataWidth-1:0]    req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [AddressWidth-1:0] paddr,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  output logic [DataWidth-1:0]    pwdata,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  // A zero-cycle limit disables the timeout; keep the counter at least 1 bit wide.
  localparam int unsigned CntW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit          TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles);

  req_state_e      state;
  logic [CntW-1:0] tmo_cnt;
  rsp_t            rsp_q;

  logic [CntW-1:0] tmo_cnt_inc_c;
  logic            tmo_hit_c;

  // Count includes the current ACCESS cycle, so abort lands after exactly TimeoutCycles cycles.
  assign tmo_cnt_inc_c = tmo_cnt + CntW'(1);
  assign tmo_hit_c     = TimeoutEn && (tmo_cnt_inc_c == CntLimit);

  assign rsp_rdata   = DataWidth'(rsp_q.rdata);
  assign rsp_error   = rsp_q.error;
  assign rsp_timeout = rsp_q.timeout;

  // Requester FSM with registered outputs and inline timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            paddr     <= req_addr;
            pwrite    <= req_write;
            pwdata    <= req_wdata;
            psel      <= 1'b1;
            penable   <= 1'b0;
            req_ready <= 1'b0;
            tmo_cnt   <= '0;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // pready beats a timeout landing on the same edge.
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_q     <= '{rdata:   pwrite ? '0 : RSP_DATA_W'(prdata),
                           error:   pslverr,
                           timeout: 1'b0};
            state     <= ST_RESP;
          end else if (tmo_hit_c) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_q     <= '{rdata: '0, error: 1'b1, timeout: 1'b1};
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt_inc_c;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_requester.sv
// Directed bench for apb3_requester with a small APB completer model
// (configurable wait states, stall, and PSLVERR injection).
module tb_apb3_requester;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready, pslverr;
  logic [DW-1:0] pwdata, prdata;

  int checks = 0;
  int errors = 0;

  apb3_requester #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .psel       (psel),
    .penable    (penable),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  // Completer model and bus monitor
  int            lat      = 0;
  bit            stall    = 1'b0;
  int            err_mode = 0;   // 0 none, 1 during ACCESS, 2 during SETUP only
  int            wcnt     = 0;
  int            cyc      = 0;
  int            setup_cnt = 0;
  int            access_cnt = 0;
  int            unstable_cnt = 0;
  logic [AW-1:0] hold_addr;
  logic          hold_write;
  logic [DW-1:0] hold_wdata;
  logic [DW-1:0] mem [0:255];

  assign pready  = psel && penable && !stall && (wcnt == lat);
  assign prdata  = mem[paddr];
  assign pslverr = (err_mode == 1) ? (psel && penable) :
                   (err_mode == 2) ? (psel && !penable) : 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (psel && !penable) begin
      setup_cnt  <= setup_cnt + 1;
      hold_addr  <= paddr;
      hold_write <= pwrite;
      hold_wdata <= pwdata;
    end
    if (psel && penable) begin
      access_cnt <= access_cnt + 1;
      if (paddr !== hold_addr || pwrite !== hold_write || pwdata !== hold_wdata)
        unstable_cnt <= unstable_cnt + 1;
    end
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  // One full transfer: returns response, cycles from accept to rsp_valid, ACCESS and SETUP counts.
  task automatic do_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output logic er, output logic to,
                         output int lat_cy, output int acc_n, output int set_n);
    int n;
    int acc0, set0, acc_cyc;
    rd = '1; er = 1'bx; to = 1'bx; lat_cy = -1; acc_n = -1; set_n = -1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_wait got req_ready=%0b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    acc0 = access_cnt; set0 = setup_cnt;
    @(negedge clk);
    acc_cyc = cyc;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_wait got rsp_valid=%0b required 1", rsp_valid);
      return;
    end
    lat_cy = cyc - acc_cyc;
    rd = rsp_rdata; er = rsp_error; to = rsp_timeout;
    acc_n = access_cnt - acc0; set_n = setup_cnt - set0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b required 0", req_ready); end
    checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL rst_psel got %0b%0b required 00", psel, penable); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b required 0", rsp_valid); end
    checks++; if (paddr !== '0 || pwdata !== '0 || pwrite !== 1'b0) begin errors++; $display("FAIL rst_bus got paddr=%0h pwdata=%0h pwrite=%0b required 0", paddr, pwdata, pwrite); end
    checks++; if (rsp_rdata !== '0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_rsp got %0h/%0b/%0b required 0", rsp_rdata, rsp_error, rsp_timeout); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %0b required 1", req_ready); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd; logic er, to; int lc, an, sn;
    lat = 0; stall = 1'b0; err_mode = 0;
    do_xfer(8'h10, 1'b1, 32'hDEADBEEF, rd, er, to, lc, an, sn);
    checks++; if (rd !== '0 || er !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL wr_rsp got %0h/%0b/%0b required 0/0/0", rd, er, to); end
    checks++; if (lc !== 2) begin errors++; $display("FAIL wr_latency got %0d required 2", lc); end
    checks++; if (sn !== 1 || an !== 1) begin errors++; $display("FAIL wr_phases got setup=%0d access=%0d required 1/1", sn, an); end
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_back_idle got rdy=%0b vld=%0b required 1/0", req_ready, rsp_valid); end
    do_xfer(8'h10, 1'b0, 32'h0, rd, er, to, lc, an, sn);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL rd_rsp got %0h/%0b required deadbeef/0", rd, er); end
    checks++; if (lc !== 2 || sn !== 1 || an !== 1) begin errors++; $display("FAIL rd_timing got lat=%0d setup=%0d access=%0d required 2/1/1", lc, sn, an); end
    checks++; if (paddr !== 8'h10 || pwrite !== 1'b0 || psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL rd_hold got paddr=%0h pwrite=%0b psel=%0b required 10/0/0", paddr, pwrite, psel); end
  endtask

  task automatic test_wait_states();
    logic [DW-1:0] rd; logic er, to; int lc, an, sn; int u0;
    lat = 2;
    do_xfer(8'h04, 1'b1, 32'h12345678, rd, er, to, lc, an, sn);
    checks++; if (er !== 1'b0 || an !== 3) begin errors++; $display("FAIL ws_wr got err=%0b access=%0d required 0/3", er, an); end
    u0 = unstable_cnt;
    do_xfer(8'h04, 1'b0, 32'h0, rd, er, to, lc, an, sn);
    checks++; if (rd !== 32'h12345678 || er !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL ws_rd got %0h/%0b/%0b required 12345678/0/0", rd, er, to); end
    checks++; if (an !== 3 || lc !== 4) begin errors++; $display("FAIL ws_timing got access=%0d lat=%0d required 3/4", an, lc); end
    checks++; if (unstable_cnt !== u0) begin errors++; $display("FAIL ws_stable got %0d changes required 0", unstable_cnt - u0); end
    lat = 0;
  endtask

  task automatic test_pslverr();
    logic [DW-1:0] rd; logic er, to; int lc, an, sn;
    err_mode = 1;
    do_xfer(8'h20, 1'b1, 32'h0BADF00D, rd, er, to, lc, an, sn);
    checks++; if (er !== 1'b1 || to !== 1'b0) begin errors++; $display("FAIL slverr_access got err=%0b tmo=%0b required 1/0", er, to); end
    err_mode = 2;
    do_xfer(8'h20, 1'b1, 32'h0BADF00D, rd, er, to, lc, an, sn);
    checks++; if (er !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL slverr_setup got err=%0b tmo=%0b required 0/0", er, to); end
    err_mode = 0;
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd; logic er, to; int lc, an, sn;
    do_xfer(8'h08, 1'b1, 32'hA5A5A5A5, rd, er, to, lc, an, sn);
    stall = 1'b1;
    do_xfer(8'h08, 1'b0, 32'h0, rd, er, to, lc, an, sn);
    checks++; if (er !== 1'b1 || to !== 1'b1 || rd !== '0) begin errors++; $display("FAIL tmo_rsp got %0h/%0b/%0b required 0/1/1", rd, er, to); end
    checks++; if (an !== 4 || lc !== 5) begin errors++; $display("FAIL tmo_timing got access=%0d lat=%0d required 4/5", an, lc); end
    checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL tmo_bus got psel=%0b penable=%0b required 0/0", psel, penable); end
    stall = 1'b0; lat = 3;
    do_xfer(8'h08, 1'b0, 32'h0, rd, er, to, lc, an, sn);
    checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0 || to !== 1'b0) begin errors++; $display("FAIL tmo_race got %0h/%0b/%0b required a5a5a5a5/0/0", rd, er, to); end
    checks++; if (an !== 4) begin errors++; $display("FAIL tmo_race_access got %0d required 4", an); end
    lat = 0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] rd; logic er, to; int lc, an, sn; int n;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h10; req_write = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    // new command waits while the response is stalled
    req_valid = 1'b1; req_addr = 8'h30; req_write = 1'b1; req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || psel !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got vld=%0b rdata=%0h rdy=%0b psel=%0b required 1/deadbeef/0/0", i, rsp_valid, rsp_rdata, req_ready, psel);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || psel !== 1'b0) begin errors++; $display("FAIL bp_release got vld=%0b rdy=%0b psel=%0b required 0/1/0", rsp_valid, req_ready, psel); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (psel !== 1'b1 || paddr !== 8'h30 || pwrite !== 1'b1) begin errors++; $display("FAIL bp_accept got psel=%0b paddr=%0h pwrite=%0b required 1/30/1", psel, paddr, pwrite); end
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    do_xfer(8'h30, 1'b0, 32'h0, rd, er, to, lc, an, sn);
    checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL bp_readback got %0h/%0b required cafef00d/0", rd, er); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic er, to; int lc, an, sn; int n; bit stale;
    stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h04; req_write = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (psel !== 1'b1 || penable !== 1'b1) begin errors++; $display("FAIL rm_in_access got psel=%0b penable=%0b required 1/1", psel, penable); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rm_async got psel=%0b penable=%0b vld=%0b rdy=%0b required 0", psel, penable, rsp_valid, req_ready); end
    stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || psel !== 1'b0) begin errors++; $display("FAIL rm_idle got rdy=%0b psel=%0b required 1/0", req_ready, psel); end
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0 || psel !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    checks++; if (stale) begin errors++; $display("FAIL rm_stale got activity after reset required none"); end
    do_xfer(8'h04, 1'b0, 32'h0, rd, er, to, lc, an, sn);
    checks++; if (rd !== 32'h12345678 || er !== 1'b0 || lc !== 2) begin errors++; $display("FAIL rm_recover got %0h/%0b lat=%0d required 12345678/0/2", rd, er, lc); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_pslverr();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion required finish");
    $fatal(1);
  end

endmodule
